// File: rtl/ltc2344_pkg.sv
// Shared types, sizes and the SoftSpan result formatter for the LTC2344-16
// CMOS interface emulator.
package ltc2344_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CONVERT = 2'b01,
    HOLD    = 2'b10
  } state_t;

  localparam int NUM_LANES     = 4;
  localparam int RESULT_BITS   = 16;
  localparam int SOFTSPAN_BITS = 12;

  localparam logic [2:0]               SS_DISABLED    = 3'b000;
  localparam logic [2:0]               SS7            = 3'b111;
  localparam logic [SOFTSPAN_BITS-1:0] SOFTSPAN_RESET = 12'hFFF;

  // Odd codes are bipolar (two's complement), even nonzero codes unipolar.
  function automatic logic [RESULT_BITS-1:0] format_result(
    input logic [2:0]             code,
    input logic [RESULT_BITS-1:0] data
  );
    logic [RESULT_BITS-1:0] res;
    res = 16'h0000;
    if (code == SS_DISABLED) begin
      res = 16'h0000;
    end else if (code[0]) begin
      res = data;
    end else begin
      res = data ^ 16'h8000;
    end
    return res;
  endfunction

endpackage

// File: rtl/ltc2344_cmos_emulator_if.sv
// Serial-side pins between the host ADC controller (master) and the
// emulated LTC2344 (slave).
interface ltc2344_cmos_emulator_if;
  import ltc2344_pkg::*;

  logic                 cnv;
  logic                 CS;
  logic                 SCKI;
  logic                 SDI;
  logic                 busy;
  logic [NUM_LANES-1:0] SDO;

  modport master (output cnv, CS, SCKI, SDI, input busy, SDO);
  modport slave  (input cnv, CS, SCKI, SDI, output busy, SDO);

endinterface

// File: rtl/ltc2344_emu_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module ltc2344_emu_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic sysClock,
  input  logic resetN,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_r;
  logic              prev_r;

  always_ff @(posedge sysClock) begin
    if (!resetN) begin
      chain_r <= {STAGES{RESET_VAL}};
      prev_r  <= RESET_VAL;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], async_in};
      prev_r  <= chain_r[STAGES-1];
    end
  end

  assign level = chain_r[STAGES-1];
  assign rise  = chain_r[STAGES-1] & ~prev_r;
  assign fall  = ~chain_r[STAGES-1] & prev_r;

endmodule

// File: rtl/ltc2344_cmos_emulator.sv
// Device-side model of the LTC2344-16 CMOS serial interface.
// Define LTC2344_EMU_RAMP_EN to replace chanData0..3 with internal ramps.
module ltc2344_cmos_emulator
  import ltc2344_pkg::*;
#(
  parameter int CONV_CYCLES = 50,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      sysClock,
  input  logic                      resetN,
  ltc2344_cmos_emulator_if.slave    bus,
  input  logic [RESULT_BITS-1:0]    chanData0,
  input  logic [RESULT_BITS-1:0]    chanData1,
  input  logic [RESULT_BITS-1:0]    chanData2,
  input  logic [RESULT_BITS-1:0]    chanData3,
  output logic [SOFTSPAN_BITS-1:0]  softspanOut,
  output logic [15:0]               convCount,
  output logic                      protoErr
);

  localparam logic [9:0] CONV_LOAD = 10'(CONV_CYCLES - 1);

  logic cnv_rise_s, cs_lvl_s, cs_rise_s, cs_fall_s, scki_rise_s, scki_fall_s, sdi_lvl_s;
  logic cnv_lvl_unused_s, cnv_fall_unused_s, scki_lvl_unused_s, sdi_rise_unused_s, sdi_fall_unused_s;

  ltc2344_emu_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cnv (
    .sysClock(sysClock), .resetN(resetN), .async_in(bus.cnv),
    .level(cnv_lvl_unused_s), .rise(cnv_rise_s), .fall(cnv_fall_unused_s));
  ltc2344_emu_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .sysClock(sysClock), .resetN(resetN), .async_in(bus.CS),
    .level(cs_lvl_s), .rise(cs_rise_s), .fall(cs_fall_s));
  ltc2344_emu_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_scki (
    .sysClock(sysClock), .resetN(resetN), .async_in(bus.SCKI),
    .level(scki_lvl_unused_s), .rise(scki_rise_s), .fall(scki_fall_s));
  ltc2344_emu_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .sysClock(sysClock), .resetN(resetN), .async_in(bus.SDI),
    .level(sdi_lvl_s), .rise(sdi_rise_unused_s), .fall(sdi_fall_unused_s));

  state_t                   state_r, state_next_s;
  logic                     busy_r;
  logic [9:0]               busy_cnt_r;
  logic [RESULT_BITS-1:0]   src_s    [NUM_LANES];
  logic [RESULT_BITS-1:0]   latch_r  [NUM_LANES];
  logic [RESULT_BITS-1:0]   result_r [NUM_LANES];
  logic [RESULT_BITS-1:0]   shift_r  [NUM_LANES];
  logic [SOFTSPAN_BITS-1:0] span_lat_r, softspan_r, cap_sr_r, cap_sr_next_s;
  logic [3:0]               cap_cnt_r, cap_cnt_next_s;
  logic [15:0]              conv_count_r;
  logic                     proto_err_r, rd_block_r, start_s, done_s, cap_en_s;
  logic [NUM_LANES-1:0]     sdo_s;

  assign start_s  = cnv_rise_s & cs_lvl_s & (state_r != CONVERT);
  assign done_s   = (state_r == CONVERT) & (busy_cnt_r == 10'd0);
  // A CS rise in the same cycle as an SCKI rise still counts as CS low for capture.
  assign cap_en_s = scki_rise_s & (~cs_lvl_s | cs_rise_s);

`ifdef LTC2344_EMU_RAMP_EN
  logic [RESULT_BITS-1:0] ramp_r [NUM_LANES];
  logic                   chan_unused_s;
  assign chan_unused_s = ^{chanData0, chanData1, chanData2, chanData3};

  always_ff @(posedge sysClock) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!resetN) begin
        ramp_r[i] <= 16'(i * 16384);
      end else if (start_s) begin
        ramp_r[i] <= ramp_r[i] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      src_s[i] = ramp_r[i];
    end
  end
`else
  always_comb begin
    src_s[0] = chanData0;
    src_s[1] = chanData1;
    src_s[2] = chanData2;
    src_s[3] = chanData3;
  end
`endif

  always_ff @(posedge sysClock) begin
    if (!resetN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = start_s ? CONVERT : IDLE;
      CONVERT: state_next_s = done_s ? HOLD : CONVERT;
      HOLD:    state_next_s = start_s ? CONVERT : HOLD;
      default: state_next_s = IDLE;
    endcase
  end

  // Span word is latched with the data so a mid-conversion commit waits for the next start.
  always_ff @(posedge sysClock) begin
    if (!resetN) begin
      busy_r       <= 1'b0;
      busy_cnt_r   <= 10'd0;
      span_lat_r   <= SOFTSPAN_RESET;
      conv_count_r <= 16'd0;
      for (int i = 0; i < NUM_LANES; i++) begin
        latch_r[i]  <= 16'h0000;
        result_r[i] <= 16'h0000;
      end
    end else if (start_s) begin
      busy_r     <= 1'b1;
      busy_cnt_r <= CONV_LOAD;
      span_lat_r <= softspan_r;
      for (int i = 0; i < NUM_LANES; i++) begin
        latch_r[i] <= src_s[i];
      end
    end else if (done_s) begin
      busy_r       <= 1'b0;
      conv_count_r <= conv_count_r + 16'd1;
      for (int i = 0; i < NUM_LANES; i++) begin
        result_r[i] <= format_result(span_lat_r[3*i +: 3], latch_r[i]);
      end
    end else if (state_r == CONVERT) begin
      busy_cnt_r <= busy_cnt_r - 10'd1;
    end
  end

  always_ff @(posedge sysClock) begin
    if (!resetN) begin
      proto_err_r <= 1'b0;
    end else if ((cnv_rise_s & ((state_r == CONVERT) | ~cs_lvl_s)) |
                 (cs_fall_s & (state_r == CONVERT))) begin
      proto_err_r <= 1'b1;
    end
  end

  // Zero-fill shifting makes SDO fall to 0 on its own after the 16th bit.
  always_ff @(posedge sysClock) begin
    if (!resetN) begin
      rd_block_r <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) shift_r[i] <= 16'h0000;
    end else if (cs_rise_s) begin
      rd_block_r <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) shift_r[i] <= 16'h0000;
    end else if (cs_fall_s) begin
      rd_block_r <= (state_r == CONVERT);
      for (int i = 0; i < NUM_LANES; i++) begin
        shift_r[i] <= (state_r == CONVERT) ? 16'h0000 : result_r[i];
      end
    end else if (scki_fall_s & ~cs_lvl_s & ~rd_block_r & (state_r != CONVERT)) begin
      for (int i = 0; i < NUM_LANES; i++) shift_r[i] <= {shift_r[i][14:0], 1'b0};
    end
  end

  always_comb begin
    cap_sr_next_s  = cap_sr_r;
    cap_cnt_next_s = cap_cnt_r;
    if (cap_en_s && (cap_cnt_r < 4'd12)) begin
      cap_sr_next_s  = {cap_sr_r[10:0], sdi_lvl_s};
      cap_cnt_next_s = cap_cnt_r + 4'd1;
    end else begin
      cap_sr_next_s  = cap_sr_r;
      cap_cnt_next_s = cap_cnt_r;
    end
  end

  always_ff @(posedge sysClock) begin
    if (!resetN) begin
      softspan_r <= SOFTSPAN_RESET;
      cap_sr_r   <= 12'h000;
      cap_cnt_r  <= 4'd0;
    end else if (cs_rise_s) begin
      if (cap_cnt_next_s >= 4'd12) softspan_r <= cap_sr_next_s;
      cap_sr_r  <= 12'h000;
      cap_cnt_r <= 4'd0;
    end else begin
      cap_sr_r  <= cap_sr_next_s;
      cap_cnt_r <= cap_cnt_next_s;
    end
  end

  always_comb begin
    sdo_s = 4'b0000;
    for (int i = 0; i < NUM_LANES; i++) sdo_s[i] = shift_r[i][15];
  end

  assign bus.busy    = busy_r;
  assign bus.SDO     = sdo_s;
  assign softspanOut = softspan_r;
  assign convCount   = conv_count_r;
  assign protoErr    = proto_err_r;

endmodule

// File: tb/tb_ltc2344_cmos_emulator.sv
// Directed bench for ltc2344_cmos_emulator: conversions push expected lane
// words to a scoreboard queue that serial readouts pop and compare.
module tb_ltc2344_cmos_emulator;

  localparam int CONV_CYCLES = 50;
  localparam int SYNC_STAGES = 2;

  logic        sysClock = 1'b0;
  logic        resetN   = 1'b0;
  logic [15:0] chanData0, chanData1, chanData2, chanData3;
  logic [11:0] softspanOut;
  logic [15:0] convCount;
  logic        protoErr;

  ltc2344_cmos_emulator_if bus();

  ltc2344_cmos_emulator #(.CONV_CYCLES(CONV_CYCLES), .SYNC_STAGES(SYNC_STAGES)) dut (
    .sysClock(sysClock), .resetN(resetN), .bus(bus),
    .chanData0(chanData0), .chanData1(chanData1), .chanData2(chanData2), .chanData3(chanData3),
    .softspanOut(softspanOut), .convCount(convCount), .protoErr(protoErr));

  always #5 sysClock = ~sysClock;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] sb[$];
  logic [11:0] exp_span;
  logic [15:0] exp_count;
  logic [15:0] ramp_m [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] fmt(input logic [2:0] code, input logic [15:0] d);
    if (code == 3'b000) return 16'h0000;
    if (code[0]) return d;
    return {~d[15], d[14:0]};
  endfunction

  function automatic logic [63:0] expect_word(input logic [63:0] d);
    logic [63:0] r;
    logic [15:0] s;
    r = 64'h0;
    for (int l = 0; l < 4; l++) begin
`ifdef LTC2344_EMU_RAMP_EN
      s = ramp_m[l];
`else
      s = d[16*l +: 16];
`endif
      r[16*l +: 16] = fmt(exp_span[3*l +: 3], s);
    end
    return r;
  endfunction

  task automatic do_reset();
    resetN = 1'b0;
    bus.cnv = 1'b0; bus.CS = 1'b1; bus.SCKI = 1'b0; bus.SDI = 1'b0;
    exp_span  = 12'hFFF;
    exp_count = 16'd0;
    for (int l = 0; l < 4; l++) ramp_m[l] = 16'(l * 16384);
    sb.delete();
    repeat (3) @(negedge sysClock);
    resetN = 1'b1;
    repeat (4) @(negedge sysClock);
  endtask

  task automatic convert(input logic [63:0] d, input int glitch_at, input int csdrop_at, input string tag);
    int lat, cnt;
    {chanData3, chanData2, chanData1, chanData0} = d;
    sb.push_back(expect_word(d));
`ifdef LTC2344_EMU_RAMP_EN
    for (int l = 0; l < 4; l++) ramp_m[l] = ramp_m[l] + 16'd1;
`endif
    exp_count = exp_count + 16'd1;
    @(negedge sysClock);
    bus.cnv = 1'b1;
    lat = 0;
    while (bus.busy !== 1'b1 && lat < 20) begin
      @(negedge sysClock);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(SYNC_STAGES + 1));
    bus.cnv = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 2000) begin
      if (cnt == glitch_at) bus.cnv = 1'b1;
      if (cnt == glitch_at + 5) bus.cnv = 1'b0;
      if (cnt == csdrop_at) bus.CS = 1'b0;
      @(negedge sysClock);
      cnt++;
    end
    check({tag, "_busy_len"}, 64'(cnt), 64'(CONV_CYCLES));
    repeat (2) @(negedge sysClock);
    check({tag, "_count"}, 64'(convCount), 64'(exp_count));
  endtask

  task automatic readout(input int nbits, input logic [31:0] sdi_bits, input bit do_cmp, input string tag);
    logic [15:0] words [4];
    logic [3:0]  tail;
    tail = 4'b0000;
    for (int l = 0; l < 4; l++) words[l] = 16'h0000;
    bus.CS = 1'b0;
    repeat (6) @(negedge sysClock);
    for (int k = 0; k < nbits; k++) begin
      bus.SDI = sdi_bits[31-k];
      repeat (2) @(negedge sysClock);
      for (int l = 0; l < 4; l++) begin
        if (k < 16) words[l][15-k] = bus.SDO[l];
        else tail[l] = tail[l] | bus.SDO[l];
      end
      bus.SCKI = 1'b1;
      repeat (4) @(negedge sysClock);
      bus.SCKI = 1'b0;
      repeat (4) @(negedge sysClock);
    end
    bus.CS = 1'b1;
    repeat (6) @(negedge sysClock);
    if (nbits >= 12) exp_span = sdi_bits[31:20];
    if (do_cmp) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
        check(tag, {words[3], words[2], words[1], words[0]}, sb.pop_front());
      end
      if (nbits > 16) check({tag, "_tail"}, 64'(tail), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] e;
    bus.cnv = 1'b0; bus.CS = 1'b1; bus.SCKI = 1'b0; bus.SDI = 1'b0;
    {chanData3, chanData2, chanData1, chanData0} = 64'h0;
    do_reset();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_sdo", 64'(bus.SDO), 64'd0);
    check("rst_span", 64'(softspanOut), 64'hFFF);
    check("rst_count", 64'(convCount), 64'd0);
    check("rst_perr", 64'(protoErr), 64'd0);

    convert(64'hFFFF_0001_8000_1234, -1, -1, "convA");
    readout(16, 32'h09F0_0000, 1'b1, "readA");
    check("spanA", 64'(softspanOut), 64'h09F);

    convert(64'hFFFF_0001_8000_1234, -1, -1, "convB");
    readout(16, 32'hFFF0_0000, 1'b1, "readB");
    check("spanB", 64'(softspanOut), 64'hFFF);

    readout(8, 32'h0000_0000, 1'b0, "short");
    check("span_short", 64'(softspanOut), 64'hFFF);

    convert(64'hCAFE_0000_7FFF_8001, -1, -1, "convD");
    readout(20, 32'hFFF0_0000, 1'b1, "readD");
    check("perr_clean", 64'(protoErr), 64'd0);

    convert(64'h0F0F_F0F0_5A5A_A5A5, -1, 20, "convE");
    check("blk_sdo0", 64'(bus.SDO), 64'd0);
    bus.SDI = 1'b1;
    repeat (4) begin
      bus.SCKI = 1'b1;
      repeat (4) @(negedge sysClock);
      bus.SCKI = 1'b0;
      repeat (4) @(negedge sysClock);
    end
    check("blk_sdo1", 64'(bus.SDO), 64'd0);
    check("blk_perr", 64'(protoErr), 64'd1);
    bus.CS = 1'b1;
    repeat (6) @(negedge sysClock);
    check("blk_span", 64'(softspanOut), 64'(exp_span));
    readout(16, 32'hFFF0_0000, 1'b1, "readE");

    do_reset();
    check("rst2_perr", 64'(protoErr), 64'd0);
    check("rst2_count", 64'(convCount), 64'd0);
    check("rst2_span", 64'(softspanOut), 64'hFFF);

    convert(64'h1357_2468_ACE0_BDF1, 10, -1, "convC");
    check("glitch_perr", 64'(protoErr), 64'd1);
    repeat (60) @(negedge sysClock);
    check("glitch_busy", 64'(bus.busy), 64'd0);
    check("glitch_count", 64'(convCount), 64'(exp_count));
    readout(16, 32'hFFF0_0000, 1'b1, "readC");

    convert(64'hFFFF_FFFF_FFFF_FFFF, -1, -1, "convR");
    bus.CS = 1'b0;
    repeat (6) @(negedge sysClock);
    if (sb.size() == 0) begin
      check("rstrd_sb_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check("rstrd_msb", 64'(bus.SDO), 64'({e[63], e[47], e[31], e[15]}));
    end
    resetN = 1'b0;
    @(negedge sysClock);
    check("rstrd_sdo0", 64'(bus.SDO), 64'd0);
    check("rstrd_busy", 64'(bus.busy), 64'd0);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
